// File: rtl/vga_timing_generator_if.sv
// Pixel-side bundle of the VGA timing generator: pixel tick and colour in,
// pixel addresses plus aligned sync/DE/colour and frame markers out.
interface vga_timing_generator_if #(
    parameter int COLOUR_W = 8,
    parameter int ADDR_W   = 10
);
    logic                pix_en;
    logic [COLOUR_W-1:0] colour_in;
    logic [ADDR_W-1:0]   addrh;
    logic [ADDR_W-1:0]   addrv;
    logic                addr_valid;
    logic                hs;
    logic                vs;
    logic                de;
    logic [COLOUR_W-1:0] colour_out;
    logic                line_start;
    logic                frame_start;

    // The timing generator itself.
    modport master (
        input  pix_en, colour_in,
        output addrh, addrv, addr_valid, hs, vs, de, colour_out,
        output line_start, frame_start
    );

    // Pixel source / DAC side.
    modport slave (
        output pix_en, colour_in,
        input  addrh, addrv, addr_valid, hs, vs, de, colour_out,
        input  line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_generator.sv
// Programmable VGA raster timing generator; sync, DE and colour are delayed
// by PIPE_LAT pixel ticks to line up with a pipelined pixel fetch.
module vga_timing_generator #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOUR_W = 8,
    parameter int PIPE_LAT = 2,
    parameter int ADDR_W   = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    vga_timing_generator_if.master io_vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DLY     = PIPE_LAT - 1;

    localparam logic [ADDR_W-1:0] H_LAST   = ADDR_W'(H_TOTAL - 1);
    localparam logic [ADDR_W-1:0] V_LAST   = ADDR_W'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] H_ACT_C  = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] V_ACT_C  = ADDR_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] HS_BEG_C = ADDR_W'(H_ACTIVE + H_FP);
    localparam logic [ADDR_W-1:0] HS_END_C = ADDR_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [ADDR_W-1:0] VS_BEG_C = ADDR_W'(V_ACTIVE + V_FP);
    localparam logic [ADDR_W-1:0] VS_END_C = ADDR_W'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
            PIPE_LAT < 1 || PIPE_LAT > 4 || COLOUR_W < 1 ||
            ADDR_W < 1 || ADDR_W > 30 ||
            (H_TOTAL - 1) >= (1 << ADDR_W) || (V_TOTAL - 1) >= (1 << ADDR_W)) begin : g_param_check
            $error("vga_timing_generator: illegal timing parameters");
        end
    endgenerate

    logic [ADDR_W-1:0] r_hcnt;
    logic [ADDR_W-1:0] r_vcnt;
    logic              r_line_start;
    logic              r_frame_start;
    logic              w_h_last;
    logic              w_v_last;
    logic              w_addr_valid;
    logic [2:0]        w_raw_flags;   // {hs, vs, de}, unpolarised
    logic [2:0]        w_dly_flags;

    assign w_h_last = (r_hcnt == H_LAST);
    assign w_v_last = (r_vcnt == V_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= io_vga.pix_en && w_h_last;
            r_frame_start <= io_vga.pix_en && w_h_last && w_v_last;
            if (io_vga.pix_en) begin
                if (w_h_last) begin
                    r_hcnt <= '0;
                    r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
                end else begin
                    r_hcnt <= r_hcnt + 1'b1;
                end
            end
        end
    end

    assign w_addr_valid      = (r_hcnt < H_ACT_C) && (r_vcnt < V_ACT_C);
    assign io_vga.addr_valid = w_addr_valid;
    assign io_vga.addrh      = w_addr_valid ? r_hcnt : '0;
    assign io_vga.addrv      = w_addr_valid ? r_vcnt : '0;

    assign w_raw_flags = {(r_hcnt >= HS_BEG_C) && (r_hcnt < HS_END_C),
                          (r_vcnt >= VS_BEG_C) && (r_vcnt < VS_END_C),
                          w_addr_valid};

    // The output register supplies one tick of latency; the rest comes from here.
    generate
        if (DLY == 0) begin : g_no_dly
            assign w_dly_flags = w_raw_flags;
        end else begin : g_dly
            for (genvar gi = 0; gi < DLY; gi++) begin : g_stage
                logic [2:0] r_q;
                logic [2:0] w_d;
                if (gi == 0) begin : g_first
                    assign w_d = w_raw_flags;
                end else begin : g_next
                    assign w_d = g_stage[gi-1].r_q;
                end
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_q <= 3'b000;
                    end else if (io_vga.pix_en) begin
                        r_q <= w_d;
                    end
                end
            end
            assign w_dly_flags = g_stage[DLY-1].r_q;
        end
    endgenerate

    logic                r_hs;
    logic                r_vs;
    logic                r_de;
    logic [COLOUR_W-1:0] r_colour;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hs     <= ~HS_POL;
            r_vs     <= ~VS_POL;
            r_de     <= 1'b0;
            r_colour <= '0;
        end else if (io_vga.pix_en) begin
            r_hs     <= w_dly_flags[2] ? HS_POL : ~HS_POL;
            r_vs     <= w_dly_flags[1] ? VS_POL : ~VS_POL;
            r_de     <= w_dly_flags[0];
            r_colour <= w_dly_flags[0] ? io_vga.colour_in : '0;
        end
    end

    assign io_vga.hs          = r_hs;
    assign io_vga.vs          = r_vs;
    assign io_vga.de          = r_de;
    assign io_vga.colour_out  = r_colour;
    assign io_vga.line_start  = r_line_start;
    assign io_vga.frame_start = r_frame_start;
endmodule
